request_queue: RTL and testbench

REQUEST_QUEUE -- requirements
Module: request_queue

---
 rtl/global_defs.sv | 39 +++
 rtl/queue_storage.sv | 56 +++++
 rtl/request_queue.sv | 126 ++++++++++++
 tb/tb_request_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_defs.sv
// Shared types and constants for the trace request queue.
// Holds the parser request format, the queue entry format, the default
// queue depth and a helper that packs the request identity tuple.
package global_defs;

    localparam int ADDRESS_WIDTH       = 32;
    localparam int DEFAULT_QUEUE_DEPTH = 16;

    typedef logic [31:0] int_t;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        int_t                     time_cpu;
        logic                     op_ready_s;
    } parser_out_struct_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        int_t                     time_cpu;
        int_t                     enq_time;
    } queue_entry_t;

    // Width of the (time_cpu, opcode, address) identity tuple.
    localparam int TUPLE_W = $bits(int_t) + $bits(parsed_op_t) + ADDRESS_WIDTH;

    // Packs the fields that identify a request for duplicate suppression.
    function automatic logic [TUPLE_W-1:0] req_tuple(input parser_out_struct_t r);
        return {r.time_cpu, r.opcode, r.address};
    endfunction

endpackage

// File: rtl/queue_storage.sv
// Circular entry store with head/tail pointers for request_queue.
// Occupancy is tracked by the caller; this block only moves pointers on
// the write/read strobes it is given. DEPTH must be a power of two so the
// pointers wrap naturally.
module queue_storage
    import global_defs::*;
#(
    parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  queue_entry_t wr_data_i,
    input  logic         rd_en_i,
    output queue_entry_t rd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    queue_entry_t     mem_q [DEPTH];

    // Next pointer values: advance by one on each strobe, wrapping at DEPTH.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (rd_en_i) begin
            head_d = head_q + PTR_W'(1);
        end
        if (wr_en_i) begin
            tail_d = tail_q + PTR_W'(1);
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage is not reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[tail_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[head_q];

endmodule

// File: rtl/request_queue.sv
// Trace request queue: gates trace requests against a simulated CPU time,
// suppresses back-to-back duplicate requests and buffers accepted ones in
// a FIFO for the downstream scheduler.
// Optional feature macro: QUEUE_TIME_SKIP_EN -- when the queue is empty and
// the presented request lies in the future, queue_time jumps straight to
// the request time instead of counting up to it.
// Handshake: an entry leaves the head on a clock edge where deq_valid and
// deq_ready are both high; deq_entry is only meaningful while deq_valid is
// high. A request is taken on the edge where it is accepted; while it is
// live but not taken, pending_request reports it one cycle later.
module request_queue
    import global_defs::*;
#(
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  parser_out_struct_t                 in_req,
    output int_t                               queue_time,
    output logic                               queue_full,
    output logic                               pending_request,
    input  logic                               deq_ready,
    output logic                               deq_valid,
    output queue_entry_t                       deq_entry,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

    logic [CNT_W-1:0]   count_q, count_d;
    int_t               time_q, time_d;
    logic               pending_q, pending_d;
    logic               last_valid_q, last_valid_d;
    logic [TUPLE_W-1:0] last_tuple_q, last_tuple_d;

    logic               req_live;
    logic [TUPLE_W-1:0] cur_tuple;
    logic               tuple_new;
    logic               accept;
    logic               dequeue;
    queue_entry_t       enq_entry;

    // Status decoded only from registered occupancy.
    assign queue_full = (count_q == CNT_W'(QUEUE_DEPTH));
    assign deq_valid  = (count_q != '0);

    // Accept/dequeue decisions from pre-edge values.
    always_comb begin
        req_live  = in_req.op_ready_s && (in_req.opcode != NOP);
        cur_tuple = req_tuple(in_req);
        tuple_new = !last_valid_q || (cur_tuple != last_tuple_q);
        accept    = req_live && !queue_full && (in_req.time_cpu <= time_q) && tuple_new;
        dequeue   = deq_valid && deq_ready;
    end

    // Entry written at the tail, stamped with the current queue time.
    always_comb begin
        enq_entry          = '0;
        enq_entry.opcode   = in_req.opcode;
        enq_entry.address  = in_req.address;
        enq_entry.time_cpu = in_req.time_cpu;
        enq_entry.enq_time = time_q;
    end

    // Occupancy, duplicate tracking and pending flag next-state.
    always_comb begin
        count_d      = count_q;
        last_valid_d = last_valid_q;
        last_tuple_d = last_tuple_q;
        pending_d    = req_live && !accept && tuple_new;
        case ({accept, dequeue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept) begin
            last_valid_d = 1'b1;
            last_tuple_d = cur_tuple;
        end
    end

    // Simulated CPU time: counts every cycle, optionally skipping ahead
    // while idle so a distant request does not stall the trace.
    always_comb begin
        time_d = time_q + 32'd1;
`ifdef QUEUE_TIME_SKIP_EN
        if ((count_q == '0) && req_live && (in_req.time_cpu > time_q)) begin
            time_d = in_req.time_cpu;
        end
`else
`endif
    end

    // Control registers, cleared asynchronously; last tuple marked invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            time_q       <= '0;
            pending_q    <= 1'b0;
            last_valid_q <= 1'b0;
            last_tuple_q <= '0;
        end else begin
            count_q      <= count_d;
            time_q       <= time_d;
            pending_q    <= pending_d;
            last_valid_q <= last_valid_d;
            last_tuple_q <= last_tuple_d;
        end
    end

    assign queue_time      = time_q;
    assign pending_request = pending_q;
    assign count           = count_q;

    queue_storage #(
        .DEPTH(QUEUE_DEPTH)
    ) u_storage (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (accept),
        .wr_data_i(enq_entry),
        .rd_en_i  (dequeue),
        .rd_data_o(deq_entry)
    );

endmodule

// File: tb/tb_request_queue.sv
// Self-checking bench for request_queue (default depth 16).
// Honours QUEUE_TIME_SKIP_EN when the same define is given to the build.
module tb_request_queue;
    import global_defs::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    parser_out_struct_t in_req = '0;
    logic               deq_ready = 1'b0;
    int_t               queue_time;
    logic               queue_full;
    logic               pending_request;
    logic               deq_valid;
    queue_entry_t       deq_entry;
    logic [CW-1:0]      count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: a plain FIFO plus time and last tuple.
    int_t               m_time;
    queue_entry_t       m_q[$];
    bit                 m_last_valid;
    logic [TUPLE_W-1:0] m_last;
    bit                 m_pending;
    queue_entry_t       exp_pop[$];
    queue_entry_t       dut_pop[$];

    always #5 clk = ~clk;

    request_queue #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_req         (in_req),
        .queue_time     (queue_time),
        .queue_full     (queue_full),
        .pending_request(pending_request),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_entry      (deq_entry),
        .count          (count)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input parsed_op_t op, input logic [31:0] addr, input int_t t);
        in_req.op_ready_s = 1'b1;
        in_req.opcode     = op;
        in_req.address    = addr;
        in_req.time_cpu   = t;
    endtask

    task automatic clear_req();
        in_req = '0;
    endtask

    // Advance one clock; the model applies the queue rules to pre-edge values.
    task automatic tick();
        bit live, full, differs, acc, deq, was_empty;
        logic [TUPLE_W-1:0] t;
        queue_entry_t e;
        t         = {in_req.time_cpu, in_req.opcode, in_req.address};
        live      = in_req.op_ready_s && (in_req.opcode != NOP);
        was_empty = (m_q.size() == 0);
        full      = (m_q.size() == DEPTH);
        differs   = !m_last_valid || (t != m_last);
        acc       = live && !full && (in_req.time_cpu <= m_time) && differs;
        deq       = !was_empty && deq_ready;
        if (deq) begin
            dut_pop.push_back(deq_entry);
            exp_pop.push_back(m_q.pop_front());
        end
        if (acc) begin
            e.opcode   = in_req.opcode;
            e.address  = in_req.address;
            e.time_cpu = in_req.time_cpu;
            e.enq_time = m_time;
            m_q.push_back(e);
            m_last       = t;
            m_last_valid = 1'b1;
        end
        m_pending = live && !acc && differs;
`ifdef QUEUE_TIME_SKIP_EN
        if (was_empty && live && (in_req.time_cpu > m_time)) m_time = in_req.time_cpu;
        else m_time = m_time + 32'd1;
`else
        m_time = m_time + 32'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        deq_ready = 1'b0;
        clear_req();
        m_q.delete();
        exp_pop.delete();
        dut_pop.delete();
        m_time       = '0;
        m_last_valid = 1'b0;
        m_last       = '0;
        m_pending    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        n_checks++; if (queue_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", queue_full); end
        n_checks++; if (pending_request !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", pending_request); end
        n_checks++; if (queue_time !== 32'd0) begin n_fail++; $display("FAIL reset_time: got %0d expected 0", queue_time); end
        apply_reset();
    endtask

    task automatic test_first_request();
        apply_reset();
        set_req(READ, 32'h1A0, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++; if (pending_request !== 1'b1) begin n_fail++; $display("FAIL first_pending_c%0d: got %b expected 1", k, pending_request); end
            n_checks++; if (count !== '0) begin n_fail++; $display("FAIL first_count_c%0d: got %0d expected 0", k, count); end
        end
        tick();
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL first_enq_count: got %0d expected 1", count); end
        n_checks++; if (deq_valid !== 1'b1) begin n_fail++; $display("FAIL first_deq_valid: got %b expected 1", deq_valid); end
        n_checks++; if (deq_entry.enq_time !== 32'd5) begin n_fail++; $display("FAIL first_enq_time: got %0d expected 5", deq_entry.enq_time); end
        n_checks++; if (deq_entry.address !== 32'h1A0) begin n_fail++; $display("FAIL first_addr: got %0h expected 1a0", deq_entry.address); end
        n_checks++; if (deq_entry.opcode !== READ) begin n_fail++; $display("FAIL first_opcode: got %0d expected %0d", deq_entry.opcode, READ); end
        n_checks++; if (pending_request !== 1'b0) begin n_fail++; $display("FAIL first_pending_after: got %b expected 0", pending_request); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_req(READ, 32'h100 + i, 32'd0);
            tick();
        end
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
        n_checks++; if (queue_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", queue_full); end
        set_req(WRITE, 32'h999, 32'd0);
        tick();
        tick();
        n_checks++; if (pending_request !== 1'b1) begin n_fail++; $display("FAIL fill_held_pending: got %b expected 1", pending_request); end
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_held_count: got %0d expected %0d", count, DEPTH); end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_checks++; if (count !== CW'(DEPTH-1)) begin n_fail++; $display("FAIL fill_deq_count: got %0d expected %0d", count, DEPTH-1); end
        n_checks++; if (pending_request !== 1'b1) begin n_fail++; $display("FAIL fill_deq_pending: got %b expected 1", pending_request); end
        tick();
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_refill_count: got %0d expected %0d", count, DEPTH); end
        n_checks++; if (pending_request !== 1'b0) begin n_fail++; $display("FAIL fill_refill_pending: got %b expected 0", pending_request); end
        n_checks++; if (dut_pop.size() != 1 || dut_pop[0].address !== 32'h100) begin n_fail++; $display("FAIL fill_first_pop: got %0d pops, expected one with address 100", dut_pop.size()); end
    endtask

    // Runs from the full state left by test_fill.
    task automatic test_back_to_back();
        int guard;
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_req((i % 2) ? WRITE : READ, 32'h200 + i, 32'd0);
            tick();
            n_checks++; if (count !== CW'(m_q.size())) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d expected %0d", i, count, m_q.size()); end
            n_checks++; if (pending_request !== m_pending) begin n_fail++; $display("FAIL b2b_pending_%0d: got %b expected %b", i, pending_request, m_pending); end
        end
        clear_req();
        guard = 0;
        while (m_q.size() != 0 && guard < 3 * DEPTH) begin
            tick();
            guard++;
        end
        deq_ready = 1'b0;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", count); end
        n_checks++; if (dut_pop.size() != exp_pop.size()) begin n_fail++; $display("FAIL b2b_pop_count: got %0d expected %0d", dut_pop.size(), exp_pop.size()); end
        for (int i = 0; i < exp_pop.size() && i < dut_pop.size(); i++) begin
            n_checks++; if (dut_pop[i] !== exp_pop[i]) begin n_fail++; $display("FAIL b2b_order_%0d: got addr %0h expected addr %0h", i, dut_pop[i].address, exp_pop[i].address); end
        end
    endtask

    task automatic test_duplicate();
        apply_reset();
        set_req(WRITE, 32'h40, 32'd3);
        repeat (10) tick();
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL dup_count: got %0d expected 1", count); end
        n_checks++; if (deq_entry.enq_time !== 32'd3) begin n_fail++; $display("FAIL dup_enq_time: got %0d expected 3", deq_entry.enq_time); end
        n_checks++; if (pending_request !== 1'b0) begin n_fail++; $display("FAIL dup_pending: got %b expected 0", pending_request); end
    endtask

    task automatic test_time_gate();
        int guard;
        apply_reset();
        tick();
        tick();
        set_req(READ, 32'h77, 32'd1000);
`ifdef QUEUE_TIME_SKIP_EN
        tick();
        n_checks++; if (queue_time !== 32'd1000) begin n_fail++; $display("FAIL skip_time: got %0d expected 1000", queue_time); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL skip_count_early: got %0d expected 0", count); end
`else
        guard = 0;
        while (queue_time != 32'd1000 && guard < 1100) begin
            tick();
            guard++;
        end
        n_checks++; if (queue_time !== 32'd1000) begin n_fail++; $display("FAIL gate_time: got %0d expected 1000", queue_time); end
        n_checks++; if (count !== '0 || pending_request !== 1'b1) begin n_fail++; $display("FAIL gate_held: got count %0d pending %b expected 0 and 1", count, pending_request); end
`endif
        tick();
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL gate_enq_count: got %0d expected 1", count); end
        n_checks++; if (deq_entry.enq_time !== 32'd1000) begin n_fail++; $display("FAIL gate_enq_time: got %0d expected 1000", deq_entry.enq_time); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            set_req(WRITE, 32'h300 + i, 32'd0);
            tick();
        end
        clear_req();
        deq_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (count !== CW'(7)) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 7", count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL mid_async_count: got %0d expected 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", deq_valid); end
        n_checks++; if (queue_time !== 32'd0) begin n_fail++; $display("FAIL mid_async_time: got %0d expected 0", queue_time); end
        apply_reset();
    endtask

    task automatic test_random();
        int_t tc;
        int   off;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                off = $urandom_range(0, 8);
                tc  = (m_time >= 32'd4) ? m_time - 32'd4 + int_t'(off) : int_t'(off);
                in_req.op_ready_s = ($urandom_range(0, 7) != 0);
                in_req.opcode     = ($urandom_range(0, 4) == 0) ? NOP : (($urandom_range(0, 1) == 0) ? READ : WRITE);
                in_req.address    = 32'($urandom_range(0, 3));
                in_req.time_cpu   = tc;
            end
            deq_ready = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            n_checks++; if (count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count_c%0d: got %0d expected %0d", c, count, m_q.size()); end
            n_checks++; if (queue_time !== m_time) begin n_fail++; $display("FAIL rnd_time_c%0d: got %0d expected %0d", c, queue_time, m_time); end
            n_checks++; if (queue_full !== (m_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full_c%0d: got %b", c, queue_full); end
            n_checks++; if (deq_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid_c%0d: got %b", c, deq_valid); end
            n_checks++; if (pending_request !== m_pending) begin n_fail++; $display("FAIL rnd_pending_c%0d: got %b expected %b", c, pending_request, m_pending); end
            if (m_q.size() != 0) begin
                n_checks++; if (deq_entry !== m_q[0]) begin n_fail++; $display("FAIL rnd_head_c%0d: got addr %0h t %0d expected addr %0h t %0d", c, deq_entry.address, deq_entry.enq_time, m_q[0].address, m_q[0].enq_time); end
            end
            tick();
        end
        n_checks++; if (dut_pop.size() != exp_pop.size()) begin n_fail++; $display("FAIL rnd_pop_count: got %0d expected %0d", dut_pop.size(), exp_pop.size()); end
        for (int i = 0; i < exp_pop.size() && i < dut_pop.size(); i++) begin
            n_checks++; if (dut_pop[i] !== exp_pop[i]) begin n_fail++; $display("FAIL rnd_order_%0d: got addr %0h expected addr %0h", i, dut_pop[i].address, exp_pop[i].address); end
        end
    endtask

    initial begin
        test_reset();
        test_first_request();
        test_fill();
        test_back_to_back();
        test_duplicate();
        test_time_gate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
